idu_ins_rx: RTL and testbench
=============================

// Module: idu_ins_rx
// PURPOSE
//  Decode-side receiver for the IFU->IDU instruction stream. It accepts 64-bit
//  instruction words on the ifu_idu_vld/idu_ifu_rdy handshake and buffers them
//  in a small FIFO. Buffered words are issued to the execute stage on the
//  idu_exu_vld/exu_idu_rdy handshake.
//  It owns idu_ifu_wfi: the signal is held high while the stream should keep
//  flowing and is dropped when a HALT opcode is accepted, which ends the fetch.
// PARAMETERS
//  DEPTH    2      FIFO entries; power of two, >=2
//  HALT_OP  8'hFF  opcode (ins[63:56]) that ends the stream
//  CNT_W    16     width of the accepted-instruction counter
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous active-low reset
//  ifu_idu_vld   in   1      IFU instruction valid
//  ifu_idu_ins   in   64     IFU instruction word
//  idu_ifu_rdy   out  1      IDU can accept a word this cycle
//  idu_ifu_wfi   out  1      keep stream alive; 0 = stop fetching
//  idu_exu_vld   out  1      head-of-FIFO instruction valid
//  idu_exu_ins   out  64     head-of-FIFO instruction word
//  exu_idu_rdy   in   1      execute stage accepts the head word
//  idu_done      out  1      1-cycle pulse: HALT issued to EXU
//  idu_ins_cnt   out  CNT_W  words accepted since last reset/done
// BEHAVIOUR
//  Clocking and reset
//  - Single clock, posedge. Reset is asynchronous and active-low on all state.
//  - Reset values: state=IDLE, FIFO empty, idu_exu_vld=0, idu_done=0,
//    idu_ins_cnt=0, idu_ifu_rdy=1, idu_ifu_wfi=1.
//  - Reset mid-stream discards all buffered words.
//  Input handshake
//  - push = ifu_idu_vld & idu_ifu_rdy.
//  - idu_ifu_rdy = !full & (state!=DRAIN). It is a function of registered
//    state only; there is no combinational path from exu_idu_rdy.
//  - ifu_idu_ins is sampled only on push. The IFU holds the word while rdy=0.
//  Output handshake
//  - pop = idu_exu_vld & exu_idu_rdy. idu_exu_vld = !empty.
//  - idu_exu_ins is the FIFO head. Latency: a pushed word is visible on
//    idu_exu_vld in the next cycle at the earliest.
//  - Push and pop in the same cycle are both performed and the count is
//    unchanged. Push when full cannot occur because rdy=0.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are
//    resolved with an occupancy counter of width log2(DEPTH)+1.
//  FSM
//  - IDLE: no word accepted yet. A push moves to RUN, or to DRAIN if the
//    pushed word has ins[63:56]==HALT_OP.
//  - RUN: a push with opcode HALT_OP moves to DRAIN.
//  - DRAIN: no further pushes. When the HALT word itself pops, go to IDLE and
//    assert idu_done for exactly one cycle (registered, the cycle after the pop).
//  - HALT is always the last word in the FIFO, so "pop while occupancy==1 in
//    DRAIN" identifies it.
//  idu_ifu_wfi
//  - idu_ifu_wfi = (state!=DRAIN) & !(push & ifu_idu_ins[63:56]==HALT_OP).
//  - It drops in the same cycle the HALT is accepted, so IFU valid falls on the
//    next edge. It returns high on re-entry to IDLE, ready for the next start.
//  Counter
//  - idu_ins_cnt increments on every push, HALT included.
//  - It saturates at all-ones and does not wrap.
//  - It clears to 0 in the cycle idu_done is asserted.
// TESTING
//  1. Reset, vld=1, ins=0x01..,0x02..,0x03.., exu_rdy=1
//     -> exu_vld one cycle after each push, in order; cnt=3; wfi stays 1.
//  2. Hold exu_rdy=0 and push 3 words
//     -> rdy=0 after 2 pushes, the 3rd word is held;
//     exu_rdy=1 -> 3rd pushed, order 1,2,3 preserved.
//  3. Push 0x05.., then HALT 0xFF..
//     -> wfi=0 in the HALT push cycle, state DRAIN, rdy=0;
//     after the HALT pops, idu_done pulses once, cnt returns to 0, wfi=1.
//  4. FIFO full with exu_rdy=1 and vld=1 every cycle
//     -> one push and one pop per cycle for 10 words, no loss or duplicate,
//     pointers wrap correctly.
//  5. rst_n low for 1 cycle with 2 words buffered in DRAIN
//     -> exu_vld=0, rdy=1, wfi=1, cnt=0 immediately (async), no idu_done pulse.
//  6. Force cnt to 16'hFFFF, push one word -> cnt stays 16'hFFFF.

Source files
------------

// File: rtl/idu_ins_rx_if.sv
// rtl/idu_ins_rx_if.sv - IFU->IDU->EXU instruction stream bundle
interface idu_ins_rx_if #(
   parameter int CNT_W = 16
) ();
   logic             ifu_idu_vld;
   logic [63:0]      ifu_idu_ins;
   logic             idu_ifu_rdy;
   logic             idu_ifu_wfi;
   logic             idu_exu_vld;
   logic [63:0]      idu_exu_ins;
   logic             exu_idu_rdy;
   logic             idu_done;
   logic [CNT_W-1:0] idu_ins_cnt;

   modport master (
      output ifu_idu_vld, ifu_idu_ins, exu_idu_rdy,
      input  idu_ifu_rdy, idu_ifu_wfi, idu_exu_vld, idu_exu_ins, idu_done, idu_ins_cnt
   );

   modport slave (
      input  ifu_idu_vld, ifu_idu_ins, exu_idu_rdy,
      output idu_ifu_rdy, idu_ifu_wfi, idu_exu_vld, idu_exu_ins, idu_done, idu_ins_cnt
   );
endinterface

// File: rtl/idu_ins_rx.sv
// rtl/idu_ins_rx.sv - IFU->IDU instruction receiver with issue FIFO
// Buffers fetched words, issues them to EXU and ends the stream on a HALT opcode.
module idu_ins_rx #(
   parameter int         DEPTH   = 2,
   parameter logic [7:0] HALT_OP = 8'hFF,
   parameter int         CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   idu_ins_rx_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_q;
   logic [63:0]        mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     occ_q;
   logic [PTR_W:0]     occ_d;
   logic               done_q;
   logic [CNT_W-1:0]   cnt_q;

   logic full;
   logic empty;
   logic rdy;
   logic push;
   logic pop;
   logic is_halt;
   logic halt_pop;

   assign full     = (occ_q == (PTR_W+1)'(DEPTH));
   assign empty    = (occ_q == '0);
   assign rdy      = !full && (state_q != ST_DRAIN);
   assign push     = bus.ifu_idu_vld && rdy;
   assign pop      = !empty && bus.exu_idu_rdy;
   assign is_halt  = (bus.ifu_idu_ins[63:56] == HALT_OP);
   // HALT is always the youngest word, so the last pop in DRAIN is the HALT.
   assign halt_pop = pop && (state_q == ST_DRAIN) && (occ_q == (PTR_W+1)'(1));

   always_comb begin
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= bus.ifu_idu_ins;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         occ_q  <= occ_d;
         done_q <= halt_pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (halt_pop) begin
            cnt_q <= '0;
         end else if (push && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (push) begin
                  state_q <= is_halt ? ST_DRAIN : ST_RUN;
               end
            end
            ST_RUN: begin
               if (push && is_halt) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (halt_pop) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.idu_ifu_rdy = rdy;
   assign bus.idu_ifu_wfi = (state_q != ST_DRAIN) && !(push && is_halt);
   assign bus.idu_exu_vld = !empty;
   assign bus.idu_exu_ins = mem_q[rd_ptr_q];
   assign bus.idu_done    = done_q;
   assign bus.idu_ins_cnt = cnt_q;
endmodule

// File: tb/tb_idu_ins_rx.sv
// tb/tb_idu_ins_rx.sv - self-checking bench for idu_ins_rx
module tb_idu_ins_rx;
   localparam int DEPTH   = 2;
   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;

   idu_ins_rx_if #(.CNT_W(CNT_W)) bus ();

   idu_ins_rx #(
      .DEPTH  (DEPTH),
      .HALT_OP(8'hFF),
      .CNT_W  (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] q[$];
   bit          drain_m;
   bit          done_m;
   int          cnt_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      drain_m = 1'b0;
      done_m  = 1'b0;
      cnt_m   = 0;
   endtask

   // One clock: drive at negedge, check just after, advance the model at posedge.
   task automatic step(input bit vld, input logic [63:0] ins, input bit erdy, output bit acc);
      bit          exp_rdy;
      bit          halt_in;
      bit          pop_m;
      logic [63:0] w;
      @(negedge clk);
      bus.ifu_idu_vld = vld;
      bus.ifu_idu_ins = ins;
      bus.exu_idu_rdy = erdy;
      #1;
      exp_rdy = (q.size() < DEPTH) && !drain_m;
      acc     = vld && exp_rdy;
      halt_in = (ins[63:56] == 8'hFF);
      chk("rdy", 64'(bus.idu_ifu_rdy), 64'(exp_rdy));
      chk("wfi", 64'(bus.idu_ifu_wfi), 64'(!drain_m && !(acc && halt_in)));
      chk("exu_vld", 64'(bus.idu_exu_vld), 64'(q.size() != 0));
      if (q.size() != 0) chk("exu_ins", bus.idu_exu_ins, q[0]);
      chk("done", 64'(bus.idu_done), 64'(done_m));
      chk("cnt", 64'(bus.idu_ins_cnt), 64'(cnt_m));
      pop_m = (q.size() != 0) && erdy;
      @(posedge clk);
      done_m = 1'b0;
      if (pop_m) begin
         w = q.pop_front();
         if (w[63:56] == 8'hFF) begin
            drain_m = 1'b0;
            done_m  = 1'b1;
            cnt_m   = 0;
         end
      end
      if (acc) begin
         q.push_back(ins);
         if (halt_in) drain_m = 1'b1;
         if (cnt_m < CNT_MAX) cnt_m++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.ifu_idu_vld = 1'b0;
      bus.exu_idu_rdy = 1'b0;
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rst_exu_vld", 64'(bus.idu_exu_vld), 64'd0);
      chk("rst_rdy", 64'(bus.idu_ifu_rdy), 64'd1);
      chk("rst_wfi", 64'(bus.idu_ifu_wfi), 64'd1);
      chk("rst_cnt", 64'(bus.idu_ins_cnt), 64'd0);
      chk("rst_done", 64'(bus.idu_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [63:0] word(input logic [7:0] op);
      return {op, 24'h00_0000, 32'($urandom)};
   endfunction

   initial begin
      bit          acc;
      bit          hold;
      logic [63:0] w;
      logic [63:0] wl[10];
      int          idx;

      rst_n = 1'b0;
      bus.ifu_idu_vld = 1'b0;
      bus.ifu_idu_ins = '0;
      bus.exu_idu_rdy = 1'b0;
      do_reset();

      // in-order issue with one-cycle latency
      for (int i = 1; i <= 3; i++) step(1'b1, word(8'(i)), 1'b1, acc);
      step(1'b0, '0, 1'b1, acc);
      chk("t1_cnt", 64'(bus.idu_ins_cnt), 64'd3);
      step(1'b0, '0, 1'b1, acc);

      // back-pressure: third word held until space frees
      step(1'b1, word(8'h11), 1'b0, acc);
      step(1'b1, word(8'h12), 1'b0, acc);
      w = word(8'h13);
      step(1'b1, w, 1'b0, acc);
      chk("t2_held", 64'(acc), 64'd0);
      do step(1'b1, w, 1'b1, acc); while (!acc);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

      // HALT ends the stream and clears the counter
      step(1'b1, word(8'h05), 1'b1, acc);
      step(1'b1, word(8'hFF), 1'b1, acc);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
      chk("t3_cnt_clr", 64'(bus.idu_ins_cnt), 64'd0);
      chk("t3_wfi", 64'(bus.idu_ifu_wfi), 64'd1);

      // streaming through a full FIFO wraps the pointers
      step(1'b1, word(8'h20), 1'b0, acc);
      step(1'b1, word(8'h21), 1'b0, acc);
      for (int i = 0; i < 10; i++) wl[i] = word(8'(8'h30 + i));
      idx = 0;
      for (int c = 0; c < 30 && idx < 10; c++) begin
         step(1'b1, wl[idx], 1'b1, acc);
         if (acc) idx++;
      end
      chk("t4_all_pushed", 64'(idx), 64'd10);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

      // async reset in DRAIN discards words, no done pulse follows
      step(1'b1, word(8'h40), 1'b0, acc);
      step(1'b1, word(8'hFF), 1'b0, acc);
      chk("t5_full", 64'(q.size()), 64'd2);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

      // counter saturates instead of wrapping
      for (int i = 0; i < CNT_MAX + 8; i++) step(1'b1, word(8'h50), 1'b1, acc);
      chk("t6_sat", 64'(bus.idu_ins_cnt), 64'(CNT_MAX));
      step(1'b1, word(8'hFF), 1'b1, acc);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

      // random traffic; the IFU keeps an unaccepted word stable
      hold = 1'b0;
      w = '0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            w = word(($urandom % 6 == 0) ? 8'hFF : 8'($urandom % 255));
         end
         if (hold || ($urandom % 4 != 0)) begin
            step(1'b1, w, ($urandom % 3) != 0, acc);
            hold = !acc;
         end else begin
            step(1'b0, w, ($urandom % 3) != 0, acc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
